// File: rtl/bean_eater_pkg.sv
// Shared definitions for the bean map: map geometry, screen limits,
// FSM state encodings, the tile-locate result record and small helpers.
// The display-side renderer imports the same package so both agree on
// the tile indexing (index = row*MAP_COLS + col).
package bean_eater_pkg;

    // Map geometry: 40x30 tiles of 16x16 pixels on a 640x480 screen
    localparam int MAP_COLS   = 40;
    localparam int MAP_ROWS   = 30;
    localparam int TILE_SHIFT = 4;
    localparam int MAP_TILES  = MAP_COLS * MAP_ROWS;
    localparam int SCR_W      = 640;
    localparam int SCR_H      = 480;
    localparam int IDX_W      = 11;

    // FSM state encodings, kept as plain constants so legacy code can share them
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Power pellet tiles sit one tile in from each corner
    localparam logic [IDX_W-1:0] PELLET_TL = IDX_W'(1  * MAP_COLS + 1);
    localparam logic [IDX_W-1:0] PELLET_TR = IDX_W'(1  * MAP_COLS + 38);
    localparam logic [IDX_W-1:0] PELLET_BL = IDX_W'(28 * MAP_COLS + 1);
    localparam logic [IDX_W-1:0] PELLET_BR = IDX_W'(28 * MAP_COLS + 38);

    // Result of mapping a pixel position onto the tile grid
    typedef struct packed {
        logic                   in_range;  // position lies on the visible screen
        logic [IDX_W-1:0]       idx;       // row*MAP_COLS + col
        logic signed [4:0]      dx;        // x offset from tile centre, -8..7
        logic signed [4:0]      dy;        // y offset from tile centre, -8..7
    } tile_loc_t;

    // Squared distance from the tile centre; the largest value is 128
    function automatic logic [7:0] dist_sq(input logic signed [4:0] dx,
                                           input logic signed [4:0] dy);
        logic signed [9:0] dxw;
        logic signed [9:0] dyw;
        dxw = 10'(dx);
        dyw = 10'(dy);
        return 8'(dxw * dxw + dyw * dyw);
    endfunction

    // True for the four corner power pellet tiles
    function automatic logic is_pellet(input logic [IDX_W-1:0] idx);
        return (idx == PELLET_TL) || (idx == PELLET_TR) ||
               (idx == PELLET_BL) || (idx == PELLET_BR);
    endfunction

endpackage

// File: rtl/bean_eater_tile_locate.sv
// tile_locate: purely combinational mapping from a pacman centre pixel
// position to its tile index, its offset from that tile's centre and
// whether the position lies on the visible 640x480 screen at all.
module tile_locate
    import bean_eater_pkg::*;
(
    input  logic [9:0] x,
    input  logic [8:0] y,
    output tile_loc_t  loc
);

    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;

    // Split the pixel position into tile coordinates and centre offsets
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path; a missed assignment turns the signal into a latch.
        row          = IDX_W'(y >> TILE_SHIFT);
        col          = IDX_W'(x >> TILE_SHIFT);
        loc.in_range = (x < 10'(SCR_W)) && (y < 9'(SCR_H));
        loc.idx      = row * IDX_W'(MAP_COLS) + col;
        loc.dx       = $signed({1'b0, x[3:0]}) - 5'sd8;
        loc.dy       = $signed({1'b0, y[3:0]}) - 5'sd8;
    end

endmodule

// File: rtl/bean_eater.sv
// bean_eater: owns the 40x30 bean occupancy map read by the renderer.
// At level start it walks the map one tile per cycle, placing a bean on
// every non-wall tile; in play it runs a two-stage eat pipeline on the
// pacman position strobes, clearing beans, counting what is left and
// accumulating a saturating score.
// Build option: define POWER_PELLET_EN to make the four corner tiles
// power pellets worth PELLET_PTS that also pulse power_pulse.
module bean_eater
    import bean_eater_pkg::*;
#(
    parameter int EAT_R2     = 16,
    parameter int BEAN_PTS   = 10,
    parameter int PELLET_PTS = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAP_TILES-1:0] wall_map,
    input  logic [9:0]           pac_x,
    input  logic [8:0]           pac_y,
    input  logic                 pos_valid,
    input  logic                 level_restart,
    output logic [MAP_TILES-1:0] beanmapData,
    output logic [IDX_W-1:0]     bean_count,
    output logic [15:0]          score,
    output logic                 eat_pulse,
    output logic                 power_pulse,
    output logic                 all_clear,
    output logic                 busy
);

    logic [0:0]        state;
    logic [IDX_W-1:0]  load_idx;

    // Stage-1 registers: the located tile for the last accepted strobe
    logic              s1_valid;
    logic [IDX_W-1:0]  s1_idx;
    logic signed [4:0] s1_dx;
    logic signed [4:0] s1_dy;

    tile_loc_t         loc;
    logic              s1_pellet;
    logic              eat_hit;
    logic [15:0]       points;
    logic [16:0]       score_sum;
    logic [15:0]       score_next;

    tile_locate u_locate (
        .x   (pac_x),
        .y   (pac_y),
        .loc (loc)
    );

`ifdef POWER_PELLET_EN
    assign s1_pellet = is_pellet(s1_idx);
`else
    assign s1_pellet = 1'b0;
`endif

    // Stage-2 decision: a bean is present and the centre is inside the eat radius
    always_comb begin
        eat_hit    = s1_valid && beanmapData[s1_idx] &&
                     (dist_sq(s1_dx, s1_dy) <= 8'(EAT_R2));
        points     = s1_pellet ? 16'(PELLET_PTS) : 16'(BEAN_PTS);
        score_sum  = {1'b0, score} + {1'b0, points};
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    // Load FSM, map register, eat pipeline, counters and score
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the map is a register vector, not a RAM, so it is reset
            // like any other state; the renderer sees an empty map at once.
            state       <= ST_LOAD;
            load_idx    <= '0;
            beanmapData <= '0;
            bean_count  <= '0;
            score       <= '0;
            eat_pulse   <= 1'b0;
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            s1_dx       <= '0;
            s1_dy       <= '0;
        end else if (level_restart) begin
            // Restart wins over any strobe or pending eat; score carries over
            state       <= ST_LOAD;
            load_idx    <= '0;
            beanmapData <= '0;
            bean_count  <= '0;
            eat_pulse   <= 1'b0;
            s1_valid    <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every read in
            // this block sees the value from before the edge.
            eat_pulse <= 1'b0;
            case (state)
                ST_LOAD: begin
                    beanmapData[load_idx] <= ~wall_map[load_idx];
                    bean_count            <= bean_count + {10'd0, ~wall_map[load_idx]};
                    s1_valid              <= 1'b0;
                    if (load_idx == IDX_W'(MAP_TILES - 1)) begin
                        state    <= ST_RUN;
                        load_idx <= '0;
                    end else begin
                        load_idx <= load_idx + 1'b1;
                    end
                end
                default: begin
                    // Stage 1: capture the located tile; off-screen positions drop out
                    s1_valid <= pos_valid && loc.in_range;
                    s1_idx   <= loc.idx;
                    s1_dx    <= loc.dx;
                    s1_dy    <= loc.dy;
                    // Stage 2: eat. The bit is known to be 1, so the count cannot underflow
                    if (eat_hit) begin
                        beanmapData[s1_idx] <= 1'b0;
                        bean_count          <= bean_count - 1'b1;
                        score               <= score_next;
                        eat_pulse           <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef POWER_PELLET_EN
    // Power pulse accompanies eat_pulse whenever the eaten tile was a pellet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            power_pulse <= 1'b0;
        end else if (level_restart || state == ST_LOAD) begin
            power_pulse <= 1'b0;
        end else begin
            power_pulse <= eat_hit && s1_pellet;
        end
    end
`else
    assign power_pulse = 1'b0;
`endif

    // Status flags derived from the registered state
    always_comb begin
        busy      = (state == ST_LOAD);
        all_clear = (state == ST_RUN) && (bean_count == '0);
    end

endmodule

// File: tb/tb_bean_eater.sv
// Directed bench for bean_eater: expected outcomes of each position strobe
// are pushed to a scoreboard when driven and popped two clocks later.
`timescale 1ns/1ps
module tb_bean_eater;

    logic          clk = 1'b0;
    logic          rst;
    logic [1199:0] wall_map;
    logic [9:0]    pac_x;
    logic [8:0]    pac_y;
    logic          pos_valid;
    logic          level_restart;
    logic [1199:0] beanmapData;
    logic [10:0]   bean_count;
    logic [15:0]   score;
    logic          eat_pulse;
    logic          power_pulse;
    logic          all_clear;
    logic          busy;

    always #5 clk = ~clk;

    bean_eater dut (
        .clk           (clk),
        .rst           (rst),
        .wall_map      (wall_map),
        .pac_x         (pac_x),
        .pac_y         (pac_y),
        .pos_valid     (pos_valid),
        .level_restart (level_restart),
        .beanmapData   (beanmapData),
        .bean_count    (bean_count),
        .score         (score),
        .eat_pulse     (eat_pulse),
        .power_pulse   (power_pulse),
        .all_clear     (all_clear),
        .busy          (busy)
    );

    typedef struct {
        logic eat;
        logic pwr;
        int   score;
        int   count;
        int   idx;
        logic bit_after;
        int   due;
    } exp_t;

    exp_t          sb[$];
    logic [1199:0] m_map;
    int            m_count;
    int            m_score;
    int            cyc     = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;
    int            n_check = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_map(input string tag, input logic [1199:0] obs, input logic [1199:0] exp);
        int diffs;
        int first;
        diffs = 0;
        first = -1;
        for (int i = 0; i < 1200; i++) begin
            if (obs[i] !== exp[i]) begin
                diffs++;
                if (first < 0) first = i;
            end
        end
        n_check++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: %0d bits differ, first at %0d (observed %b expected %b)",
                   tag, diffs, first, obs[first], exp[first]);
        end
    endtask

    // Advance one clock, then compare every scoreboard entry due now
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("eat_pulse",   {31'd0, eat_pulse},   {31'd0, e.eat});
            check("power_pulse", {31'd0, power_pulse}, {31'd0, e.pwr});
            check("score",       {16'd0, score},       e.score);
            check("bean_count",  {21'd0, bean_count},  e.count);
            check("map_bit",     {31'd0, beanmapData[e.idx]}, {31'd0, e.bit_after});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one position strobe and push what the DUT should do with it
    task automatic pos(input int x, input int y);
        exp_t e;
        logic in_rng;
        logic pel;
        int   dx;
        int   dy;
        int   idx;
        in_rng = (x < 640) && (y < 480);
        idx    = in_rng ? (y / 16) * 40 + (x / 16) : 0;
        dx     = (x % 16) - 8;
        dy     = (y % 16) - 8;
`ifdef POWER_PELLET_EN
        pel = (idx == 41) || (idx == 78) || (idx == 1121) || (idx == 1158);
`else
        pel = 1'b0;
`endif
        e.eat = in_rng && m_map[idx] && (dx * dx + dy * dy <= 16);
        e.pwr = e.eat && pel;
        if (e.eat) begin
            m_map[idx] = 1'b0;
            m_count--;
            m_score = m_score + (pel ? 50 : 10);
            if (m_score > 65535) m_score = 65535;
        end
        e.score     = m_score;
        e.count     = m_count;
        e.idx       = idx;
        e.bit_after = m_map[idx];
        e.due       = cyc + 2;
        sb.push_back(e);
        pac_x     = 10'(x);
        pac_y     = 9'(y);
        pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
    endtask

    task automatic restart();
        level_restart = 1'b1;
        tick();
        level_restart = 1'b0;
    endtask

    // Wait for LOAD to end (bounded), then check the loaded map against the walls
    task automatic wait_load(input int exp_len);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("load_len", n, exp_len);
        m_map   = ~wall_map;
        m_count = $countones(~wall_map);
        check_map("loaded_map", beanmapData, m_map);
        check("loaded_count", {21'd0, bean_count}, m_count);
        check("busy_after_load", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        wall_map      = '0;
        pac_x         = 10'd8;
        pac_y         = 9'd8;
        pos_valid     = 1'b0;
        level_restart = 1'b0;
        m_map         = '0;
        m_count       = 0;
        m_score       = 0;
        #12;
        check_map("rst_map", beanmapData, '0);
        check("rst_count", {21'd0, bean_count}, 32'd0);
        check("rst_score", {16'd0, score}, 32'd0);
        check("rst_eat", {31'd0, eat_pulse}, 32'd0);
        check("rst_power", {31'd0, power_pulse}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_all_clear", {31'd0, all_clear}, 32'd0);

        // Level 1: empty walls; strobes held high during LOAD must be ignored
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pos_valid = 1'b1;
        wait_load(1200);
        pos_valid = 1'b0;
        check("all_clear_full", {31'd0, all_clear}, 32'd0);
        idle(2);
        check("no_eat_after_load", {31'd0, eat_pulse}, 32'd0);
        check("count_after_load", {21'd0, bean_count}, 32'd1200);

        // Basic eat at tile (1,1), then repeats and an out-of-radius strobe
        pos(24, 24);
        idle(1);
        check("bit41_cleared", {31'd0, beanmapData[41]}, 32'd0);
        pos(24, 24);
        pos(30, 24);
        idle(2);
        check("bit42_kept", {31'd0, beanmapData[42]}, 32'd1);

        // Back-to-back strobes, including a repeat on the tile just eaten
        pos(40, 24);
        pos(56, 24);
        pos(56, 24);
        idle(2);
        check("pulse_one_cycle", {31'd0, eat_pulse}, 32'd0);

        // Off-screen positions and radius boundaries (16 eats, 18 does not)
        pos(640, 24);
        pos(100, 480);
        pos(84, 88);
        pos(117, 85);
        idle(2);

        // Single-bean level: eat it, all_clear holds, restart keeps the score
        wall_map    = '1;
        wall_map[0] = 1'b0;
        restart();
        wait_load(1200);
        pos(8, 8);
        idle(1);
        check("all_clear_set", {31'd0, all_clear}, 32'd1);
        idle(3);
        check("all_clear_held", {31'd0, all_clear}, 32'd1);
        restart();
        check("all_clear_drop", {31'd0, all_clear}, 32'd0);
        check("busy_on_restart", {31'd0, busy}, 32'd1);
        check("score_kept", {16'd0, score}, m_score);

        // Restart part-way through LOAD starts the walk again from tile 0
        idle(100);
        wall_map = '0;
        restart();
        wait_load(1200);

        // Restart together with a strobe: the strobe is discarded
        pac_x         = 10'd24;
        pac_y         = 9'd24;
        pos_valid     = 1'b1;
        level_restart = 1'b1;
        tick();
        pos_valid     = 1'b0;
        level_restart = 1'b0;
        tick();
        check("restart_no_eat1", {31'd0, eat_pulse}, 32'd0);
        tick();
        check("restart_no_eat2", {31'd0, eat_pulse}, 32'd0);
        wait_load(1198);
        check("bit41_reloaded", {31'd0, beanmapData[41]}, 32'd1);
        check("score_unchanged", {16'd0, score}, m_score);

        // Tile (1,1) again: a power pellet only in POWER_PELLET_EN builds
        pos(24, 24);
        idle(2);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
